// File: rtl/mar_pkg.sv
// mar_pkg: shared state encoding and mode constants for the memory address register
package mar_pkg;
  typedef enum logic [1:0] {
    S_RUN        = 2'd0,
    S_PROG_ENTRY = 2'd1,
    S_PROG       = 2'd2
  } state_t;
  localparam logic MODE_RUN  = 1'b0;
  localparam logic MODE_PROG = 1'b1;
endpackage

// File: rtl/mar_reg.sv
// mar_reg: address register with sync clear, load and increment wrapping at MEM_DEPTH
module mar_reg #(
  parameter int ADDR_W    = 4,
  parameter int MEM_DEPTH = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              ld,
  input  logic              inc,
  input  logic [ADDR_W-1:0] d,
  output logic [ADDR_W-1:0] q,
  output logic              wrap
);
  localparam logic [ADDR_W-1:0] TOP = ADDR_W'(MEM_DEPTH - 1);
  logic w_top;
  assign w_top = (q == TOP);
  always_ff @(posedge clk) begin
    if (clr) begin
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      q    <= ld ? d : inc ? (w_top ? '0 : q + 1'b1) : q;
      wrap <= ~ld & inc & w_top;
    end
  end
endmodule

// File: rtl/mar_seq.sv
// mar_seq: SAP memory address register with run/program modes and range check.
// Optional tristate output (oe_n) enabled by defining MAR_TRISTATE_EN.
module mar_seq
  import mar_pkg::*;
#(
  parameter int ADDR_W    = 4,
  parameter int MEM_DEPTH = 16
) (
  input  logic              clk,
  input  logic              clr,
`ifdef MAR_TRISTATE_EN
  input  logic              oe_n,
`endif
  input  logic              mode,
  input  logic [ADDR_W-1:0] bus_in,
  input  logic [ADDR_W-1:0] sw_in,
  input  logic              ld1_n,
  input  logic              ld2_n,
  input  logic              inc,
  output logic [ADDR_W-1:0] mar_out,
  output logic              addr_upd,
  output logic              wrap,
  output logic              range_err
);
  localparam logic [ADDR_W:0] LIM = (ADDR_W + 1)'(MEM_DEPTH);
  state_t            r_state, w_next;
  logic              w_load, w_want, w_oor, w_ld, w_inc, w_wrap, r_upd, r_err;
  logic [ADDR_W-1:0] w_cand, w_q;
  always_comb begin
    w_load = ~ld1_n & ~ld2_n;
    w_cand = (r_state == S_RUN) ? bus_in : sw_in;
    w_want = (r_state == S_PROG_ENTRY) | w_load;
    w_oor  = ({1'b0, w_cand} >= LIM);
    w_ld   = w_want & ~w_oor;
    w_inc  = (r_state == S_PROG) & ~w_load & inc;
    w_next = (mode == MODE_PROG) ? ((r_state == S_RUN) ? S_PROG_ENTRY : S_PROG) : S_RUN;
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= S_RUN;
      r_upd   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_upd   <= w_ld | w_inc;
      r_err   <= r_err | (w_want & w_oor);
    end
  end
  mar_reg #(.ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH)) u_reg (
    .clk  (clk),
    .clr  (clr),
    .ld   (w_ld),
    .inc  (w_inc),
    .d    (w_cand),
    .q    (w_q),
    .wrap (w_wrap)
  );
  assign addr_upd  = r_upd;
  assign range_err = r_err;
  assign wrap      = w_wrap;
`ifdef MAR_TRISTATE_EN
  assign mar_out = oe_n ? 'z : w_q;
`else
  assign mar_out = w_q;
`endif
endmodule

// File: tb/tb_mar_seq.sv
// tb_mar_seq: random and directed checks of mar_seq (depths 16 and 12) against a behavioural model
module tb_mar_seq;
  logic       clk = 1'b0;
  logic       clr, mode, ld1_n, ld2_n, inc;
  logic [3:0] bus_in, sw_in;
  logic [3:0] q16, q12;
  logic       u16, w16, e16, u12, w12, e12;
`ifdef MAR_TRISTATE_EN
  logic       oe_n = 1'b0;
`endif
  int total = 0, bad = 0;
  int m_mar[2], m_upd[2], m_wrap[2], m_err[2];
  bit m_prog[2], m_ent[2];
  int depth[2] = '{16, 12};

  always #5 clk = ~clk;

  mar_seq #(.ADDR_W(4), .MEM_DEPTH(16)) u16_dut (
    .clk(clk), .clr(clr),
`ifdef MAR_TRISTATE_EN
    .oe_n(oe_n),
`endif
    .mode(mode), .bus_in(bus_in), .sw_in(sw_in), .ld1_n(ld1_n), .ld2_n(ld2_n), .inc(inc),
    .mar_out(q16), .addr_upd(u16), .wrap(w16), .range_err(e16));

  mar_seq #(.ADDR_W(4), .MEM_DEPTH(12)) u12_dut (
    .clk(clk), .clr(clr),
`ifdef MAR_TRISTATE_EN
    .oe_n(oe_n),
`endif
    .mode(mode), .bus_in(bus_in), .sw_in(sw_in), .ld1_n(ld1_n), .ld2_n(ld2_n), .inc(inc),
    .mar_out(q12), .addr_upd(u12), .wrap(w12), .range_err(e12));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step_model();
    for (int k = 0; k < 2; k++) begin
      bit was_prog, do_ld;
      int cand;
      if (clr) begin
        m_mar[k] = 0; m_upd[k] = 0; m_wrap[k] = 0; m_err[k] = 0;
        m_prog[k] = 0; m_ent[k] = 0;
        continue;
      end
      do_ld = m_ent[k] || (!ld1_n && !ld2_n);
      cand  = (m_prog[k] || m_ent[k]) ? int'(sw_in) : int'(bus_in);
      m_upd[k] = 0; m_wrap[k] = 0;
      if (do_ld) begin
        if (cand >= depth[k]) m_err[k] = 1;
        else begin m_mar[k] = cand; m_upd[k] = 1; end
      end else if (m_prog[k] && inc) begin
        m_upd[k] = 1;
        if (m_mar[k] == depth[k] - 1) begin m_mar[k] = 0; m_wrap[k] = 1; end
        else m_mar[k] = m_mar[k] + 1;
      end
      was_prog = m_prog[k] || m_ent[k];
      m_prog[k] = mode && was_prog;
      m_ent[k]  = mode && !was_prog;
    end
  endtask

  task automatic cyc();
    step_model();
    @(posedge clk);
    #1;
    chk("mar16", 32'(q16), m_mar[0]);
    chk("upd16", 32'(u16), m_upd[0]);
    chk("wrap16", 32'(w16), m_wrap[0]);
    chk("err16", 32'(e16), m_err[0]);
    chk("mar12", 32'(q12), m_mar[1]);
    chk("upd12", 32'(u12), m_upd[1]);
    chk("wrap12", 32'(w12), m_wrap[1]);
    chk("err12", 32'(e12), m_err[1]);
  endtask

  initial begin
    clr = 1; mode = 0; ld1_n = 1; ld2_n = 1; inc = 0; bus_in = 0; sw_in = 0;
    cyc(); cyc();
    chk("rst_mar", 32'(q16), 0);
    clr = 0;
    bus_in = 4'hA; ld1_n = 0; ld2_n = 0; cyc();
    chk("run_load", 32'(q16), 32'hA);
    chk("run_upd", 32'(u16), 1);
    ld1_n = 1; ld2_n = 1; cyc();
    chk("upd_once", 32'(u16), 0);
    bus_in = 5; ld1_n = 0; cyc();
    chk("single_en", 32'(q16), 32'hA);
    ld1_n = 1; inc = 1; cyc();
    chk("run_inc", 32'(q16), 32'hA);
    inc = 0; sw_in = 3; mode = 1; cyc(); cyc();
    chk("entry", 32'(q16), 3);
    inc = 1; cyc(); cyc(); cyc();
    chk("step", 32'(q16), 6);
    inc = 0; sw_in = 15; ld1_n = 0; ld2_n = 0; cyc();
    chk("err12_sw15", 32'(e12), 1);
    ld1_n = 1; ld2_n = 1; inc = 1; cyc();
    chk("wrap_mar", 32'(q16), 0);
    chk("wrap_pulse", 32'(w16), 1);
    inc = 0; ld1_n = 0; ld2_n = 0; cyc();
    sw_in = 7; inc = 1; cyc();
    chk("ld_beats_inc", 32'(q16), 7);
    chk("no_wrap", 32'(w16), 0);
    inc = 0; mode = 0; cyc();
    bus_in = 13; cyc();
    chk("oor_hold", 32'(q12), 7);
    bus_in = 11; cyc();
    chk("ok_after_err", 32'(q12), 11);
    chk("err_sticky", 32'(e12), 1);
    ld1_n = 1; ld2_n = 1; mode = 1; sw_in = 2; cyc(); cyc();
    inc = 1; cyc();
    clr = 1; cyc();
    chk("clr_mid_inc", 32'(q16), 0);
    clr = 0; inc = 0; mode = 1; cyc(); mode = 0; cyc(); mode = 1; sw_in = 9; cyc(); cyc();
    chk("reentry", 32'(q16), 9);
`ifdef MAR_TRISTATE_EN
    oe_n = 1; #1;
    chk("hiz", {28'd0, q16}, {28'd0, 4'bzzzz});
    oe_n = 0; #1;
    chk("oe_drive", 32'(q16), 9);
`endif
    for (int n = 0; n < 3000; n++) begin
      clr    = ($urandom_range(0, 63) == 0);
      mode   = ($urandom_range(0, 7) == 0) ? ~mode : mode;
      ld1_n  = ($urandom_range(0, 3) != 0);
      ld2_n  = ($urandom_range(0, 1) != 0);
      inc    = ($urandom_range(0, 1) != 0);
      bus_in = 4'($urandom);
      sw_in  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom);
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
